// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Opcodes, FSM encoding and latency constants for seq_alu_param.
// Revision    : 1.0
// ============================================================================
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULS = 3'd2;
    localparam logic [2:0] OP_MULU = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_Q = 3'd1,
        S_LOAD_M = 3'd2,
        S_EXEC   = 3'd3,
        S_CORR   = 3'd4,
        S_OUT_HI = 3'd5,
        S_OUT_LO = 3'd6
    } state_t;

    // Cycle (counted from the start-sampling cycle) that carries finish.
    localparam int LAT_ADD = 4;

    function automatic int lat_mul(input int w);
        return w + 4;
    endfunction

    function automatic int lat_div(input int w);
        return w + 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_param.sv
`default_nettype none
// ============================================================================
// Module      : rca_param
// Description : N-bit ripple-carry adder with carry-out and signed overflow.
// Revision    : 1.0
// ============================================================================
module rca_param #(
    parameter int N = 17
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_ci,
    output logic [N-1:0] o_sum,
    output logic         o_co,
    output logic         o_ovf
);

    logic w_cin_msb;

    always_comb begin : p_ripple
        logic w_c;
        w_c       = i_ci;
        w_cin_msb = 1'b0;
        o_sum     = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) w_cin_msb = w_c;
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_co = w_c;
    end

    assign o_ovf = o_co ^ w_cin_msb;

endmodule
`default_nettype wire

// File: rtl/seq_alu_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_param
// Description : Multi-cycle ALU: serial operand load, add/sub, Booth and
//               unsigned multiply, non-restoring divide, serial result out.
// Revision    : 1.0
// ============================================================================
module seq_alu_param
    import seq_alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [2:0]   s,
    input  logic [W-1:0] inbus,
    output logic [W-1:0] outbus,
    output logic         out_valid,
    output logic         busy,
    output logic         finish,
    output logic         negative,
    output logic         zero,
    output logic         carry,
    output logic         overflow,
    output logic         div_by_zero
);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic [W:0]    r_a;       // extra MSB is the partial-remainder sign for DIVU
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_m;
    logic          r_q1;
    logic [CW-1:0] r_cnt;
    logic          r_neg, r_zero, r_carry, r_ovf, r_dbz;

    logic [W:0]    w_add_a, w_add_b, w_sum;
    logic          w_add_ci, w_add_co, w_add_ovf;
    logic          w_last, w_m_zero;
    logic          w_unused_adder;

    assign w_last         = (r_cnt == CW'(W - 1));
    assign w_m_zero       = (r_m == '0);
    assign w_unused_adder = w_add_co ^ w_add_ovf;

    rca_param #(.N(W + 1)) u_rca (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_ci  (w_add_ci),
        .o_sum (w_sum),
        .o_co  (w_add_co),
        .o_ovf (w_add_ovf)
    );

    always_comb begin
        w_add_a  = {1'b0, r_q};
        w_add_b  = {1'b0, r_m};
        w_add_ci = 1'b0;
        case (r_op)
            OP_SUB: begin
                w_add_b  = {1'b0, ~r_m};
                w_add_ci = 1'b1;
            end
            OP_MULS: begin
                // Sign-extended operands keep A +/- M exact even for M = -2^(W-1)
                w_add_a = {r_a[W-1], r_a[W-1:0]};
                case ({r_q[0], r_q1})
                    2'b01:   w_add_b = {r_m[W-1], r_m};
                    2'b10: begin
                        w_add_b  = ~{r_m[W-1], r_m};
                        w_add_ci = 1'b1;
                    end
                    default: w_add_b = '0;
                endcase
            end
            OP_MULU: begin
                w_add_a = {1'b0, r_a[W-1:0]};
                w_add_b = r_q[0] ? {1'b0, r_m} : '0;
            end
            OP_DIVU: begin
                if (r_state == S_CORR) begin
                    w_add_a = r_a;
                end else begin
                    w_add_a = {r_a[W-1:0], r_q[W-1]};
                    if (!r_a[W]) begin
                        w_add_b  = ~{1'b0, r_m};
                        w_add_ci = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD_Q;
            S_LOAD_Q: w_next = S_LOAD_M;
            S_LOAD_M: w_next = S_EXEC;
            S_EXEC: begin
                case (r_op)
                    OP_ADD, OP_SUB:   w_next = S_OUT_LO;
                    OP_MULS, OP_MULU: if (w_last) w_next = S_OUT_HI;
                    OP_DIVU: begin
                        if (w_m_zero)    w_next = S_OUT_HI;
                        else if (w_last) w_next = S_CORR;
                    end
                    default:          w_next = S_OUT_LO;
                endcase
            end
            S_CORR:   w_next = S_OUT_HI;
            S_OUT_HI: w_next = S_OUT_LO;
            S_OUT_LO: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_op    <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   if (start) r_op <= s;
                S_LOAD_Q: r_q <= inbus;
                S_LOAD_M: begin
                    r_m   <= inbus;
                    r_a   <= '0;
                    r_q1  <= 1'b0;
                    r_cnt <= '0;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ADD, OP_SUB: r_a <= {1'b0, w_sum[W-1:0]};
                        OP_MULS, OP_MULU: begin
                            r_a   <= {w_sum[W], w_sum[W:1]};
                            r_q   <= {w_sum[0], r_q[W-1:1]};
                            r_q1  <= r_q[0];
                            r_cnt <= r_cnt + 1'b1;
                        end
                        OP_DIVU: begin
                            if (w_m_zero) begin
                                r_a <= {1'b0, r_q};
                                r_q <= '1;
                            end else begin
                                r_a   <= w_sum;
                                r_q   <= {r_q[W-2:0], ~w_sum[W]};
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_CORR: if (r_a[W]) r_a <= w_sum;
                default: ;
            endcase

            if (w_next == S_OUT_LO) begin
                r_dbz   <= (r_op == OP_DIVU) && w_m_zero;
                r_neg   <= 1'b0;
                r_zero  <= 1'b0;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
                case (r_op)
                    OP_ADD, OP_SUB: begin
                        r_neg   <= w_sum[W-1];
                        r_zero  <= (w_sum[W-1:0] == '0);
                        r_carry <= w_sum[W];
                        r_ovf   <= (r_q[W-1] == w_add_b[W-1]) && (w_sum[W-1] != r_q[W-1]);
                    end
                    OP_MULS: begin
                        r_neg  <= r_a[W-1];
                        r_zero <= ({r_a[W-1:0], r_q} == '0);
                        r_ovf  <= (r_a[W-1:0] != {W{r_q[W-1]}});
                    end
                    OP_MULU: begin
                        r_neg  <= r_a[W-1];
                        r_zero <= ({r_a[W-1:0], r_q} == '0);
                        r_ovf  <= (r_a[W-1:0] != '0);
                    end
                    OP_DIVU: r_zero <= (r_q == '0);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        outbus = '0;
        case (r_state)
            S_OUT_HI: outbus = r_a[W-1:0];
            S_OUT_LO: begin
                case (r_op)
                    OP_ADD, OP_SUB:            outbus = r_a[W-1:0];
                    OP_MULS, OP_MULU, OP_DIVU: outbus = r_q;
                    default:                   outbus = '0;
                endcase
            end
            default: ;
        endcase
    end

    assign out_valid   = (r_state == S_OUT_HI) || (r_state == S_OUT_LO);
    assign finish      = (r_state == S_OUT_LO);
    assign busy        = (r_state != S_IDLE);
    assign negative    = r_neg;
    assign zero        = r_zero;
    assign carry       = r_carry;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu_param
// Description : Self-checking bench for seq_alu_param against an arithmetic model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seq_alu_param;
    import seq_alu_pkg::*;

    localparam int W      = 16;
    localparam int CW     = $clog2(W) + 1;
    localparam int BUDGET = 64;
    localparam int N_RAND = 40;

    logic         clk   = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   s     = 3'd0;
    logic [W-1:0] inbus = '0;
    logic [W-1:0] outbus;
    logic         out_valid, busy, finish;
    logic         negative, zero, carry, overflow, div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu_param #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .s           (s),
        .inbus       (inbus),
        .outbus      (outbus),
        .out_valid   (out_valid),
        .busy        (busy),
        .finish      (finish),
        .negative    (negative),
        .zero        (zero),
        .carry       (carry),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           has_hi;
        int           lo_cyc;
        logic [3:0]   flags;   // {negative, zero, carry, overflow}
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    // Captured by run_op
    logic [W-1:0] cap_hi, cap_lo;
    int           cap_hi_cyc, cap_lo_cyc, cap_hi_cnt;
    bit           cap_timeout, cap_busy_ok, cap_quiet_ok;
    logic [3:0]   cap_flags;
    logic         cap_dbz;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint full = longint'(1) << W;
        longint ux   = longint'(x);
        longint uy   = longint'(y);
        longint sx   = x[W-1] ? ux - full : ux;
        longint sy   = y[W-1] ? uy - full : uy;
        longint r, t, p;
        logic   n, z, c, v;
        e.hi = '0; e.lo = '0; e.has_hi = 0; e.lo_cyc = LAT_ADD; e.dbz = 1'b0;
        n = 1'b0; z = 1'b0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r = (op == OP_ADD) ? ux + uy : ux - uy + full;
                t = (op == OP_ADD) ? sx + sy : sx - sy;
                e.lo = W'(r);
                c = (r >= full);
                v = (t >= full / 2) || (t < -(full / 2));
                n = e.lo[W-1];
                z = (e.lo == '0);
            end
            OP_MULS, OP_MULU: begin
                p = (op == OP_MULS) ? sx * sy : ux * uy;
                e.has_hi = 1;
                e.hi = W'(p >>> W);
                e.lo = W'(p);
                e.lo_cyc = lat_mul(W);
                n = p[2*W-1];
                z = (p == 0);
                v = (op == OP_MULS) ? ((p >= full / 2) || (p < -(full / 2))) : (p >= full);
            end
            OP_DIVU: begin
                e.has_hi = 1;
                if (uy == 0) begin
                    e.hi = x;
                    e.lo = '1;
                    e.lo_cyc = 5;
                    e.dbz = 1'b1;
                end else begin
                    e.hi = W'(ux % uy);
                    e.lo = W'(ux / uy);
                    e.lo_cyc = lat_div(W);
                end
                z = (e.lo == '0);
            end
            default: ;
        endcase
        e.flags = {n, z, c, v};
        return e;
    endfunction

    // Drives one operation starting at the next falling edge (cycle 0) and
    // captures the result words; glitch_cyc raises start mid-operation.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int glitch_cyc);
        cap_hi = '0; cap_lo = '0; cap_hi_cyc = -1; cap_lo_cyc = -1; cap_hi_cnt = 0;
        cap_timeout = 1; cap_busy_ok = 1; cap_quiet_ok = 1; cap_flags = '0; cap_dbz = 1'b0;
        @(negedge clk);
        start = 1'b1; s = op; inbus = W'($urandom);
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            start = (cyc == glitch_cyc);
            s     = start ? OP_ADD : 3'($urandom_range(0, 7));
            inbus = (cyc == 1) ? x : (cyc == 2) ? y : W'($urandom);
            if (!busy) cap_busy_ok = 0;
            if (!out_valid && outbus != '0) cap_quiet_ok = 0;
            if (out_valid && !finish) begin
                cap_hi = outbus; cap_hi_cyc = cyc; cap_hi_cnt++;
            end
            if (finish) begin
                cap_lo = outbus; cap_lo_cyc = cyc;
                cap_flags = {negative, zero, carry, overflow};
                cap_dbz = div_by_zero;
                cap_timeout = 0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (outbus !== '0) begin errors++; $display("FAIL reset outbus: got %h want 0", outbus); end
        checks++;
        if ({out_valid, busy, finish} !== 3'b000) begin
            errors++; $display("FAIL reset handshake: got %b want 000", {out_valid, busy, finish});
        end
        checks++;
        if ({negative, zero, carry, overflow, div_by_zero} !== 5'b0) begin
            errors++; $display("FAIL reset flags: got %b want 00000", {negative, zero, carry, overflow, div_by_zero});
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b want 0", busy); end
    endtask

    task automatic test_arith();
        vec_t v[$];
        exp_t e;
        string nm;
        v.push_back('{OP_ADD,  16'h7FFF, 16'h0001});
        v.push_back('{OP_SUB,  16'h0005, 16'h0005});
        v.push_back('{OP_SUB,  16'h0003, 16'h0005});
        v.push_back('{OP_MULS, 16'hFFFD, 16'h0007});
        v.push_back('{OP_MULU, 16'hFFFF, 16'hFFFF});
        v.push_back('{OP_MULS, 16'h8000, 16'h8000});
        v.push_back('{OP_DIVU, 16'd100,  16'd7});
        v.push_back('{OP_DIVU, 16'hFFFF, 16'h0001});
        v.push_back('{OP_DIVU, 16'h0005, 16'h0009});
        v.push_back('{OP_DIVU, 16'h1234, 16'h0000});
        v.push_back('{3'd6,    16'hAAAA, 16'h5555});
        for (int i = 0; i < N_RAND; i++) begin
            vec_t r;
            r.op = 3'($urandom_range(0, 7));
            r.x  = W'($urandom);
            r.y  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            v.push_back(r);
        end
        foreach (v[k]) begin
            e = model(v[k].op, v[k].x, v[k].y);
            run_op(v[k].op, v[k].x, v[k].y, 0);
            nm = $sformatf("op%0d %h,%h", v[k].op, v[k].x, v[k].y);
            checks++;
            if (cap_timeout) begin errors++; $display("FAIL %s timeout: no finish within %0d cycles", nm, BUDGET); end
            checks++;
            if (cap_lo !== e.lo) begin errors++; $display("FAIL %s lo word: got %h want %h", nm, cap_lo, e.lo); end
            checks++;
            if (cap_lo_cyc != e.lo_cyc) begin errors++; $display("FAIL %s finish cycle: got %0d want %0d", nm, cap_lo_cyc, e.lo_cyc); end
            checks++;
            if (cap_hi_cnt != (e.has_hi ? 1 : 0)) begin
                errors++; $display("FAIL %s hi word count: got %0d want %0d", nm, cap_hi_cnt, e.has_hi ? 1 : 0);
            end
            if (e.has_hi) begin
                checks++;
                if (cap_hi !== e.hi) begin errors++; $display("FAIL %s hi word: got %h want %h", nm, cap_hi, e.hi); end
                checks++;
                if (cap_hi_cyc != e.lo_cyc - 1) begin errors++; $display("FAIL %s hi cycle: got %0d want %0d", nm, cap_hi_cyc, e.lo_cyc - 1); end
            end
            checks++;
            if (cap_flags !== e.flags) begin errors++; $display("FAIL %s flags nzcv: got %b want %b", nm, cap_flags, e.flags); end
            checks++;
            if (cap_dbz !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, cap_dbz, e.dbz); end
            checks++;
            if (!cap_busy_ok) begin errors++; $display("FAIL %s busy: got 0 want 1 during operation", nm); end
            checks++;
            if (!cap_quiet_ok) begin errors++; $display("FAIL %s outbus: got nonzero want 0 while out_valid=0", nm); end
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        e = model(OP_MULS, 16'hFFFD, 16'h0007);
        run_op(OP_MULS, 16'hFFFD, 16'h0007, 8);
        checks++;
        if ({cap_hi, cap_lo} !== {e.hi, e.lo}) begin
            errors++; $display("FAIL start_ignored product: got %h%h want %h%h", cap_hi, cap_lo, e.hi, e.lo);
        end
        checks++;
        if (cap_lo_cyc != e.lo_cyc) begin errors++; $display("FAIL start_ignored finish cycle: got %0d want %0d", cap_lo_cyc, e.lo_cyc); end
        // A start raised during the operation must not launch a second one
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_ignored idle after finish: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1;
        @(negedge clk);
        start = 1'b1; s = OP_MULS;
        @(negedge clk); start = 1'b0; inbus = 16'h1234;
        @(negedge clk); inbus = 16'h0567;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid busy before reset: got %b want 1", busy); end
        rst_b = 1'b0;
        #1;
        checks++;
        if ({outbus, out_valid, busy, finish, negative, zero, carry, overflow, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %h %b want all 0", outbus,
                     {out_valid, busy, finish, negative, zero, carry, overflow, div_by_zero});
        end
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || out_valid || finish) quiet = 0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL reset_mid aborted op: got activity after reset want none"); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [W-1:0] a, b;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom);
            e = model(OP_ADD, a, b);
            run_op(OP_ADD, a, b, 0);
            checks++;
            if (cap_lo !== e.lo || cap_lo_cyc != LAT_ADD) begin
                errors++; $display("FAIL back_to_back add %0d: got %h@%0d want %h@%0d", i, cap_lo, cap_lo_cyc, e.lo, LAT_ADD);
            end
        end
        run_op(OP_DIVU, 16'h1234, 16'h0000, 0);
        checks++;
        if (cap_dbz !== 1'b1) begin errors++; $display("FAIL dbz set: got %b want 1", cap_dbz); end
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz hold: got %b want 1", div_by_zero); end
        e = model(OP_ADD, 16'h0001, 16'h0002);
        run_op(OP_ADD, 16'h0001, 16'h0002, 0);
        checks++;
        if (cap_dbz !== 1'b0) begin errors++; $display("FAIL dbz clear by add: got %b want 0", cap_dbz); end
        checks++;
        if (cap_lo !== e.lo) begin errors++; $display("FAIL add after dbz: got %h want %h", cap_lo, e.lo); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/seq_alu_param.md
Name: seq_alu_param

Overview:
- Parametrised multi-cycle integer ALU; successor to the fixed 16-bit A/Q/M sequential ALU.
- Width is a parameter. Adds unsigned multiply, a non-restoring divide with remainder correction, a divide-by-zero flag, and busy/out_valid handshakes.
- Operands arrive serially on inbus; results leave serially on outbus.
- Sits on the processor datapath bus as the arithmetic coprocessor driven by the control unit.

Parameters:
- W, 16, operand/result word width (W >= 4).
- CW, $clog2(W)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- s  input  3  opcode, captured with start: 0 ADD, 1 SUB, 2 MULS (signed, Booth radix-2), 3 MULU, 4 DIVU; 5-7 illegal.
- inbus  input  W  operand input: X on cycle 1, Y on cycle 2 after start.
- outbus  output  W  result word; 0 whenever out_valid=0.
- out_valid  output  1  outbus carries a result word.
- busy  output  1  operation in progress.
- finish  output  1  one-cycle pulse coincident with the last result word.
- negative, zero, carry, overflow  output  1 each  status flags.
- div_by_zero  output  1  last DIVU had Y=0.

Behaviour:
- Reset (async, rst_b=0): FSM to IDLE; all registers, counter, outputs and flags are 0. Reset mid-operation aborts with no output.
- Clock/reset as decided: one clock; reset is asynchronous and active-low.
- States: IDLE, LOAD_Q, LOAD_M, EXEC, CORR, OUT_HI, OUT_LO.
- Cycle 0 (IDLE, start=1): latch s; next state LOAD_Q.
- Cycle 1 (LOAD_Q): Q<=inbus (X). Cycle 2 (LOAD_M): M<=inbus (Y), A<=0, counter<=0.
- busy=1 from cycle 1 through the finish cycle inclusive. start while busy is ignored.
- ADD/SUB: EXEC is one cycle. A<=X+Y, or X+~Y+1, through a (W+1)-bit adder. OUT_LO at cycle 4.
  - outbus=result. carry = adder carry-out (SUB: 1 means no borrow). overflow = signed overflow. negative = result MSB. zero = result==0.
- MULS: W Booth steps on A:Q:q_1 (cycles 3..W+2), each add/sub M then arithmetic right shift. OUT_HI at W+3 (outbus=A), OUT_LO at W+4 (outbus=Q).
- MULU: same sequence, using add-and-shift with the carry shifted into the A MSB.
- Multiply flags:
  - negative = product bit 2W-1.
  - zero = 2W-bit product==0.
  - carry = 0.
  - overflow: MULS, product not sign-extension of its low word; MULU, high word != 0.
- DIVU, non-restoring:
  - Iterations run cycles 3..W+2; each shifts A:Q left, adds or subtracts M by A's sign, and sets Q[0]=~A sign.
  - CORR at W+3: if A<0 then A<=A+M.
  - OUT_HI at W+4 (remainder), OUT_LO at W+5 (quotient).
  - Flags: zero = quotient==0; negative, carry, overflow = 0.
- Y=0 on DIVU: detected in EXEC at cycle 3, no iterations.
  - quotient = all ones, remainder = X; div_by_zero=1.
  - OUT_HI at cycle 4, OUT_LO at cycle 5.
- Illegal opcode: EXEC goes directly to OUT_LO (cycle 4) with outbus=0; all flags cleared.
- Flag update timing:
  - Flags and div_by_zero update on entry to OUT_LO and hold until the next OUT_LO or reset.
  - div_by_zero is cleared by any op other than a divide-by-zero DIVU.
- Counter: increments per iteration; exits iterations when counter==W-1; never wraps in normal use.
- OUT_LO always returns to IDLE. start may be reasserted on the cycle after finish.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams (OP_ADD..OP_DIVU);
  - the state encoding;
  - the latency constants LAT_ADD=4, LAT_MUL=W+4, LAT_DIV=W+5.
- One sub-module: rca_param. A (W+1)-bit ripple-carry adder with ci, co and signed overflow outputs, shared by all operations.
- A/Q/M registers, counter and FSM stay in the top module.

Test Plan (W=16):
- ADD 0x7FFF+0x0001 -> outbus 0x8000 at cycle 4, finish=1, negative=1, overflow=1, carry=0, zero=0.
- SUB 0x0005-0x0005 -> outbus 0x0000, zero=1, carry=1, overflow=0. Also 0x0003-0x0005 -> 0xFFFE, carry=0, negative=1.
- MULS 0xFFFD(-3)*0x0007 -> OUT_HI 0xFFFF at cycle 19, OUT_LO 0xFFEB at cycle 20 with finish, negative=1, overflow=0. MULU 0xFFFF*0xFFFF -> 0xFFFE / 0x0001, overflow=1.
- DIVU 100/7 -> remainder 0x0002 at cycle 20, quotient 0x000E at cycle 21 with finish. DIVU 0xFFFF/0x0001 -> 0x0000 / 0xFFFF.
- DIVU 0x1234/0 -> div_by_zero=1; outbus 0x1234 then 0xFFFF; finish at cycle 5; next ADD clears div_by_zero.
- Control: start pulsed during a MULS is ignored and the result is unchanged. rst_b low at cycle 10 of a MULS -> all outputs 0 immediately, IDLE. Back-to-back ADD restarted on the cycle after finish completes correctly. Opcode 6 -> outbus 0, finish at cycle 4.
